// File: rtl/issue_unit_pkg.sv
// Shared types and default latencies for the issue unit.
// Source ids name which execution unit owns a CDB broadcast slot.
package issue_unit_pkg;

  localparam int unsigned TAG_W  = 6;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned DEF_INT_LAT = 1;
  localparam int unsigned DEF_LS_LAT  = 2;
  localparam int unsigned DEF_MUL_LAT = 3;
  localparam int unsigned DEF_DIV_LAT = 6;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_INT  = 3'd1,
    SRC_LS   = 3'd2,
    SRC_MUL  = 3'd3,
    SRC_DIV  = 3'd4
  } src_e;

endpackage

// File: rtl/issue_unit_if.sv
// Issue-queue handshakes, unit result buses and the CDB broadcast.
// slave = issue_unit side, master = queue/unit/consumer side.
interface issue_unit_if;
  import issue_unit_pkg::*;

  logic              i_flush;
  logic              i_int_ready, i_ls_ready, i_mul_ready, i_div_ready;
  logic              o_int_rd, o_ls_rd, o_mul_rd, o_div_rd;
  logic [TAG_W-1:0]  i_int_tag, i_ls_tag, i_mul_tag, i_div_tag;
  logic [DATA_W-1:0] i_int_data, i_ls_data, i_mul_data, i_div_data;
  logic              i_int_branch, i_int_branch_taken;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_branch, cdb_branch_taken;

  modport slave (
    input  i_flush,
    input  i_int_ready, i_ls_ready, i_mul_ready, i_div_ready,
    output o_int_rd, o_ls_rd, o_mul_rd, o_div_rd,
    input  i_int_tag, i_ls_tag, i_mul_tag, i_div_tag,
    input  i_int_data, i_ls_data, i_mul_data, i_div_data,
    input  i_int_branch, i_int_branch_taken,
    output cdb_valid, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken
  );

  modport master (
    output i_flush,
    output i_int_ready, i_ls_ready, i_mul_ready, i_div_ready,
    input  o_int_rd, o_ls_rd, o_mul_rd, o_div_rd,
    output i_int_tag, i_ls_tag, i_mul_tag, i_div_tag,
    output i_int_data, i_ls_data, i_mul_data, i_div_data,
    output i_int_branch, i_int_branch_taken,
    input  cdb_valid, cdb_tag, cdb_data, cdb_branch, cdb_branch_taken
  );

endinterface

// File: rtl/issue_unit_cdb_slot_sreg.sv
// CDB reservation shift register: slot[k] owns the bus k cycles from now.
// Shifts toward slot[0] every cycle, with an optional insert at one index.
module cdb_slot_sreg
  import issue_unit_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DIV_LAT,
  parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             ins_en,
  input  logic [IDX_W-1:0] ins_idx,
  input  src_e             ins_src,
  output src_e             head,
  output logic [DEPTH-1:0] busy
);

  src_e slot_q [DEPTH];
  src_e slot_d [DEPTH];

  always_comb begin
    slot_d[DEPTH-1] = SRC_NONE;
    for (int unsigned k = 0; k < DEPTH - 1; k++) begin
      slot_d[k] = slot_q[k+1];
    end
    // The issuer only inserts where the shifted-in value is NONE.
    if (ins_en) begin
      slot_d[ins_idx] = ins_src;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (rst || clear) begin
        slot_q[k] <= SRC_NONE;
      end else begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      busy[k] = (slot_q[k] != SRC_NONE);
    end
  end

  assign head = slot_q[0];

endmodule

// File: rtl/issue_unit.sv
// Fixed-priority issue arbiter (DIV > MUL > LS > INT) that reserves a
// collision-free CDB slot per issued op, plus the CDB result mux.
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int unsigned INT_LAT = DEF_INT_LAT,
  parameter int unsigned LS_LAT  = DEF_LS_LAT,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT,
  parameter int unsigned DIV_LAT = DEF_DIV_LAT
) (
  input logic         i_clk,
  input logic         i_rst,
  issue_unit_if.slave bus
);

  localparam int unsigned IDX_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
  localparam int unsigned CNT_W = $clog2(DIV_LAT + 1);

  logic             kill;
  logic [DIV_LAT-1:0] busy;
  logic [DIV_LAT:0] busy_ext;
  src_e             head;
  src_e             sel;
  logic [IDX_W-1:0] ins_idx;
  logic [CNT_W-1:0] div_busy_cnt;
  logic             int_ok, ls_ok, mul_ok, div_ok;

  assign kill = i_rst || bus.i_flush;

  // Extra top bit stands for slot[DIV_LAT], which never holds an owner.
  assign busy_ext = {1'b0, busy};

  assign int_ok = bus.i_int_ready && !busy_ext[INT_LAT];
  assign ls_ok  = bus.i_ls_ready  && !busy_ext[LS_LAT];
  assign mul_ok = bus.i_mul_ready && !busy_ext[MUL_LAT];
  assign div_ok = bus.i_div_ready && !busy_ext[DIV_LAT] && (div_busy_cnt == '0);

  always_comb begin
    sel     = SRC_NONE;
    ins_idx = '0;
    if (!kill) begin
      if (div_ok)      sel = SRC_DIV;
      else if (mul_ok) sel = SRC_MUL;
      else if (ls_ok)  sel = SRC_LS;
      else if (int_ok) sel = SRC_INT;
    end
    case (sel)
      SRC_INT: ins_idx = IDX_W'(INT_LAT - 1);
      SRC_LS:  ins_idx = IDX_W'(LS_LAT - 1);
      SRC_MUL: ins_idx = IDX_W'(MUL_LAT - 1);
      SRC_DIV: ins_idx = IDX_W'(DIV_LAT - 1);
      default: ins_idx = '0;
    endcase
  end

  assign bus.o_int_rd = (sel == SRC_INT);
  assign bus.o_ls_rd  = (sel == SRC_LS);
  assign bus.o_mul_rd = (sel == SRC_MUL);
  assign bus.o_div_rd = (sel == SRC_DIV);

  cdb_slot_sreg #(
    .DEPTH (DIV_LAT),
    .IDX_W (IDX_W)
  ) u_slots (
    .clk     (i_clk),
    .rst     (i_rst),
    .clear   (bus.i_flush),
    .ins_en  (sel != SRC_NONE),
    .ins_idx (ins_idx),
    .ins_src (sel),
    .head    (head),
    .busy    (busy)
  );

  // Loaded one short: the issue cycle itself is the first of the DIV_LAT
  // busy cycles, so a new divide may issue exactly DIV_LAT cycles later.
  always_ff @(posedge i_clk) begin
    if (kill) begin
      div_busy_cnt <= '0;
    end else if (sel == SRC_DIV) begin
      div_busy_cnt <= CNT_W'(DIV_LAT - 1);
    end else if (div_busy_cnt != '0) begin
      div_busy_cnt <= div_busy_cnt - 1'b1;
    end
  end

  always_comb begin
    bus.cdb_valid        = 1'b0;
    bus.cdb_tag          = '0;
    bus.cdb_data         = '0;
    bus.cdb_branch       = 1'b0;
    bus.cdb_branch_taken = 1'b0;
    if (!kill) begin
      case (head)
        SRC_INT: begin
          bus.cdb_valid        = 1'b1;
          bus.cdb_tag          = bus.i_int_tag;
          bus.cdb_data         = bus.i_int_data;
          bus.cdb_branch       = bus.i_int_branch;
          bus.cdb_branch_taken = bus.i_int_branch_taken;
        end
        SRC_LS: begin
          bus.cdb_valid = 1'b1;
          bus.cdb_tag   = bus.i_ls_tag;
          bus.cdb_data  = bus.i_ls_data;
        end
        SRC_MUL: begin
          bus.cdb_valid = 1'b1;
          bus.cdb_tag   = bus.i_mul_tag;
          bus.cdb_data  = bus.i_mul_data;
        end
        SRC_DIV: begin
          bus.cdb_valid = 1'b1;
          bus.cdb_tag   = bus.i_div_tag;
          bus.cdb_data  = bus.i_div_data;
        end
        default: ;
      endcase
    end
  end

endmodule
